// File: rtl/alu_md.sv
// alu_md: multi-cycle ALU for the MIPS EX stage.
// Single-cycle add/sub/logic/shift/slt and HI/LO moves finish in one clock.
// mult (shift-add) and div (restoring) take WIDTH iterations plus a FINISH
// cycle, during which in_ready is low so the pipeline stalls.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   in_valid/ready   request handshake; accept when both high
//   ALUCtrl, Sign    operation code, signed-operation select
//   in1, in2         operands (in1[SH_W-1:0] is the shift amount)
//   out_valid        one-cycle result pulse
//   out, zero        registered result and (out == 0)
//   hi, lo           HI/LO register contents
module alu_md #(
  parameter int WIDTH = 32,
  parameter int SH_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       ALUCtrl,
  input  logic             Sign,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN_MUL = 2'd1;
  localparam logic [1:0] S_RUN_DIV = 2'd2;
  localparam logic [1:0] S_FINISH  = 2'd3;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_NOR  = 5'b00101;
  localparam logic [4:0] OP_SLL  = 5'b00110;
  localparam logic [4:0] OP_SRL  = 5'b00111;
  localparam logic [4:0] OP_SRA  = 5'b01000;
  localparam logic [4:0] OP_SLT  = 5'b01001;
  localparam logic [4:0] OP_MULT = 5'b01010;
  localparam logic [4:0] OP_DIV  = 5'b01011;
  localparam logic [4:0] OP_MFHI = 5'b01100;
  localparam logic [4:0] OP_MFLO = 5'b01101;
  localparam logic [4:0] OP_MTHI = 5'b01110;
  localparam logic [4:0] OP_MTLO = 5'b01111;

  logic [1:0]       r_state;
  logic [SH_W-1:0]  r_cnt;
  logic [WIDTH-1:0] r_a;      // multiplicand / divisor magnitude
  logic [WIDTH-1:0] r_q;      // multiplier -> low product, dividend -> quotient
  logic [WIDTH:0]   r_acc;    // high product (with carry) / partial remainder
  logic             r_is_div;
  logic             r_neg_q;  // negate product or quotient at FINISH
  logic             r_neg_r;  // negate remainder at FINISH
  logic             r_div0;
  logic [WIDTH-1:0] r_dvd;    // original dividend, returned in hi on divide-by-zero
  logic [WIDTH-1:0] r_hi, r_lo, r_out;
  logic             r_zero, r_out_valid;

  logic             w_accept;
  logic [WIDTH-1:0] w_mag1, w_mag2, w_alu;
  logic [SH_W-1:0]  w_shamt;
  logic [WIDTH:0]   w_msum, w_shift, w_acc_n;
  logic [WIDTH+1:0] w_diff;
  logic [WIDTH-1:0] w_q_n;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_fin_hi, w_fin_lo;

  assign in_ready  = (r_state == S_IDLE);
  assign w_accept  = in_valid && in_ready;
  assign w_shamt   = in1[SH_W-1:0];
  assign w_mag1    = (Sign && in1[WIDTH-1]) ? -in1 : in1;
  assign w_mag2    = (Sign && in2[WIDTH-1]) ? -in2 : in2;

  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign zero      = r_zero;
  assign hi        = r_hi;
  assign lo        = r_lo;

  always_comb begin
    w_alu = '0;
    case (ALUCtrl)
      OP_ADD:  w_alu = in1 + in2;
      OP_SUB:  w_alu = in1 - in2;
      OP_AND:  w_alu = in1 & in2;
      OP_OR:   w_alu = in1 | in2;
      OP_XOR:  w_alu = in1 ^ in2;
      OP_NOR:  w_alu = ~(in1 | in2);
      OP_SLL:  w_alu = in2 << w_shamt;
      OP_SRL:  w_alu = in2 >> w_shamt;
      OP_SRA:  w_alu = $signed(in2) >>> w_shamt;
      OP_SLT:  w_alu[0] = Sign ? ($signed(in1) < $signed(in2)) : (in1 < in2);
      OP_MFHI: w_alu = r_hi;
      OP_MFLO: w_alu = r_lo;
      OP_MTHI: w_alu = in1;
      OP_MTLO: w_alu = in1;
      default: w_alu = '0;
    endcase
  end

  // One iteration: mult adds the multiplicand when the multiplier LSB is set,
  // then shifts {acc,q} right; div shifts the next dividend bit into the
  // remainder and keeps the trial subtraction only when it does not borrow.
  always_comb begin
    w_msum  = r_acc + (r_q[0] ? {1'b0, r_a} : '0);
    w_shift = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
    w_diff  = {1'b0, w_shift} - {2'b00, r_a};
    if (r_state == S_RUN_DIV) begin
      if (!w_diff[WIDTH+1]) begin
        w_acc_n = w_diff[WIDTH:0];
        w_q_n   = {r_q[WIDTH-2:0], 1'b1};
      end else begin
        w_acc_n = w_shift;
        w_q_n   = {r_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      w_acc_n = {1'b0, w_msum[WIDTH:1]};
      w_q_n   = {w_msum[0], r_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    w_prod = {r_acc[WIDTH-1:0], r_q};
    if (r_neg_q) w_prod = -w_prod;
    if (r_is_div) begin
      if (r_div0) begin
        w_fin_lo = '1;
        w_fin_hi = r_dvd;
      end else begin
        w_fin_lo = r_neg_q ? -r_q : r_q;
        w_fin_hi = r_neg_r ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
      end
    end else begin
      w_fin_hi = w_prod[2*WIDTH-1:WIDTH];
      w_fin_lo = w_prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_a         <= '0;
      r_q         <= '0;
      r_acc       <= '0;
      r_is_div    <= 1'b0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_div0      <= 1'b0;
      r_dvd       <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_out       <= '0;
      r_zero      <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (ALUCtrl == OP_MULT || ALUCtrl == OP_DIV) begin
              r_is_div <= (ALUCtrl == OP_DIV);
              r_state  <= (ALUCtrl == OP_DIV) ? S_RUN_DIV : S_RUN_MUL;
              r_cnt    <= '0;
              r_acc    <= '0;
              r_a      <= (ALUCtrl == OP_DIV) ? w_mag2 : w_mag1;
              r_q      <= (ALUCtrl == OP_DIV) ? w_mag1 : w_mag2;
              r_neg_q  <= Sign && (in1[WIDTH-1] ^ in2[WIDTH-1]);
              r_neg_r  <= Sign && in1[WIDTH-1];
              r_div0   <= (in2 == '0);
              r_dvd    <= in1;
            end else begin
              r_out       <= w_alu;
              r_zero      <= (w_alu == '0);
              r_out_valid <= 1'b1;
              if (ALUCtrl == OP_MTHI) r_hi <= in1;
              if (ALUCtrl == OP_MTLO) r_lo <= in1;
            end
          end
        end
        S_RUN_MUL, S_RUN_DIV: begin
          r_acc <= w_acc_n;
          r_q   <= w_q_n;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == SH_W'(WIDTH-1)) r_state <= S_FINISH;
        end
        default: begin
          r_hi        <= w_fin_hi;
          r_lo        <= w_fin_lo;
          r_out       <= w_fin_lo;
          r_zero      <= (w_fin_lo == '0);
          r_out_valid <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_md.md
# alu_md

Parametrised multi-cycle ALU for the MIPS datapath. It keeps the existing single-cycle operation set (add/sub, logic, shifts, slt) and adds an iterative multiplier and divider with HI/LO registers and mfhi/mflo/mthi/mtlo. A valid/ready handshake lets the pipeline stall on mult/div. It sits in the EX stage, driven by the ALU control decoder.

## Interface
- WIDTH, 32: operand, result and HI/LO width; must be a power of two ≥ 8.
- SH_W, $clog2(WIDTH): number of shift-amount bits taken from in1.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset; one clock, reset is synchronous and active-high.
- in_valid  in  1  operation request.
- in_ready  out  1  combinational, (state==IDLE); an op is accepted on an edge where in_valid && in_ready.
- ALUCtrl  in  5  operation code.
- Sign  in  1  1 = signed add/sub/slt/mult/div.
- in1, in2  in  WIDTH  operands.
- out_valid  out  1  registered; one-cycle result pulse.
- out  out  WIDTH  registered result, held until the next result.
- zero  out  1  registered, (out==0), updated together with out.
- hi, lo  out  WIDTH  HI/LO register contents.

## Operation
- Single-cycle codes:
  - 00000 add, 00001 sub (wrap mod 2^WIDTH, no overflow trap).
  - 00010 and, 00011 or, 00100 xor, 00101 nor.
  - 00110 sll: in2 << in1[SH_W-1:0].
  - 00111 srl.
  - 01000 sra: $signed(in2) >>> in1[SH_W-1:0].
  - 01001 slt: 1 if in1 < in2, signed when Sign=1, else unsigned.
- 01100 mfhi → out=hi. 01101 mflo → out=lo.
- 01110 mthi: hi=in1, out=in1. 01111 mtlo: lo=in1, out=in1.
- 01010 mult: {hi,lo} = in1*in2, 2·WIDTH-bit product, signed if Sign.
  - Iterative shift-add on magnitudes, one bit per cycle, sign fixed in FINISH.
  - out=lo result.
- 01011 div: restoring division, one quotient bit per cycle.
  - lo=quotient, truncated toward zero; hi=remainder, sign of dividend.
  - out=quotient.
- Divisor 0, either Sign: lo = all ones, hi = in1.
- Signed MIN / -1: lo = MIN, hi = 0.
- Any other code: out=0, zero=1, latency 1, hi/lo unchanged.
- State machine:
  - IDLE --accept mult--> RUN_MUL. IDLE --accept div--> RUN_DIV.
  - RUN_* stays WIDTH cycles (counter 0..WIDTH-1), then → FINISH.
  - FINISH → IDLE; writes hi/lo, out, zero, and pulses out_valid.
- Requests while in_ready=0 are not accepted. The master holds in_valid, ALUCtrl and operands; they are not sampled until acceptance.

## Timing
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, out=0, zero=1, hi=0, lo=0.
  - Iteration counter and work registers = 0.
- Single-cycle op accepted at edge E: out/zero/out_valid are visible after E; latency 1.
  - Back-to-back accepts give one result per cycle.
  - out_valid stays high continuously during back-to-back results.
- mult/div accepted at edge E:
  - in_ready low from after E.
  - Iterations on edges E+1..E+WIDTH; FINISH at edge E+WIDTH+1.
  - out_valid is high for exactly the cycle after E+WIDTH+1; latency WIDTH+1 (33 at WIDTH=32).
  - in_ready is high again in that same cycle, so a new op can be accepted on the same edge that drops out_valid.
- mfhi issued the cycle after mult's out_valid returns the new hi (no hazard).
- Reset in any state, including mid-RUN or FINISH:
  - Aborts the operation; no out_valid is produced.
  - hi/lo are cleared.
  - in_ready=1 in the following cycle.
- Reset wins over a simultaneous accept.

## Test plan
- Reset, then add, Sign=1, in1=5, in2=0xFFFFFFFD → next cycle out=2, zero=0, out_valid=1.
  - Then sub 7-7 → out=0, zero=1.
- sra in1=4, in2=0x80000000 → 0xF8000000. sll in1=33, in2=1 → 0x00000002 (only in1[4:0] used). Issue both back-to-back: two consecutive out_valid cycles.
- mult Sign=1, 0xFFFFFFFE×3 → out_valid exactly 33 cycles after accept, in_ready=0 throughout, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - Same operands with Sign=0 → hi=0x00000002, lo=0xFFFFFFFA.
  - A following mfhi → 0x00000002.
- div Sign=1:
  - -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - 9/0 → lo=0xFFFFFFFF, hi=9.
  - 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Assert reset on cycle 10 of a div → no out_valid, hi=lo=0, in_ready=1 the next cycle; a subsequent add completes normally.
- Undefined code 0x1F → out=0, zero=1, latency 1. mthi 0x1234 then mfhi → 0x1234.
